// File: rtl/cache_ctrl_fsm_pkg.sv
// Shared types and defaults for the data-cache control FSM.
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_MEM,
    FILL,
    WR_MEM
  } state_e;

  localparam int MEM_LAT_DEF = 4;

endpackage

// File: rtl/cache_ctrl_fsm_if.sv
// CPU/datapath/memory handshake bundle around the cache controller.
interface cache_ctrl_fsm_if;

  logic MemRead;
  logic MemWrite;
  logic hit;
  logic stall;
  logic mem_read;
  logic mem_write;
  logic cache_fill;
  logic cache_word_we;

  modport master (
    output MemRead, MemWrite, hit,
    input  stall, mem_read, mem_write, cache_fill, cache_word_we
  );

  modport slave (
    input  MemRead, MemWrite, hit,
    output stall, mem_read, mem_write, cache_fill, cache_word_we
  );

endinterface

// File: rtl/cache_ctrl_fsm_sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Control FSM for a direct-mapped, write-through, no-write-allocate data cache.
module cache_ctrl_fsm
  import cache_ctrl_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  cache_ctrl_fsm_if.slave  bus,
  output logic [CNT_W-1:0] rd_hits,
  output logic [CNT_W-1:0] rd_misses
);

  localparam int WCNT_W = $clog2(MEM_LAT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              refilled_q, refilled_d;

  logic stall, mem_read, mem_write, cache_fill, cache_word_we;
  logic hit_inc, miss_inc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      refilled_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      refilled_q <= refilled_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    refilled_d    = refilled_q;
    stall         = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    cache_fill    = 1'b0;
    cache_word_we = 1'b0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A read takes priority over a simultaneous write.
        if (bus.MemRead) begin
          if (bus.hit) begin
            hit_inc    = !refilled_q;
            refilled_d = 1'b0;
          end else begin
            stall    = 1'b1;
            miss_inc = 1'b1;
            state_d  = RD_MEM;
            wcnt_d   = '0;
          end
        end else if (bus.MemWrite) begin
          stall         = 1'b1;
          cache_word_we = bus.hit;
          state_d       = WR_MEM;
          wcnt_d        = '0;
        end
      end
      RD_MEM: begin
        mem_read = 1'b1;
        stall    = 1'b1;
        wcnt_d   = wcnt_q + 1'b1;
        if (wcnt_q == WCNT_LAST) state_d = FILL;
      end
      FILL: begin
        cache_fill = 1'b1;
        stall      = 1'b1;
        refilled_d = 1'b1;
        state_d    = IDLE;
      end
      WR_MEM: begin
        mem_write = 1'b1;
        // Stall drops on the final memory cycle so the store retires exactly once.
        if (wcnt_q == WCNT_LAST) begin
          state_d = IDLE;
        end else begin
          stall  = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst) begin
      stall         = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      cache_fill    = 1'b0;
      cache_word_we = 1'b0;
      hit_inc       = 1'b0;
      miss_inc      = 1'b0;
    end
  end

  assign bus.stall         = stall;
  assign bus.mem_read      = mem_read;
  assign bus.mem_write     = mem_write;
  assign bus.cache_fill    = cache_fill;
  assign bus.cache_word_we = cache_word_we;

  sat_counter #(.CNT_W(CNT_W)) u_hits (
    .clk_i (clk),
    .clr_i (!rst),
    .inc_i (hit_inc),
    .cnt_o (rd_hits)
  );

  sat_counter #(.CNT_W(CNT_W)) u_misses (
    .clk_i (clk),
    .clr_i (!rst),
    .inc_i (miss_inc),
    .cnt_o (rd_misses)
  );

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed self-checking bench for cache_ctrl_fsm (MEM_LAT=4).
module tb_cache_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rd_hits, rd_misses;
  logic [1:0]  rd_hits2, rd_misses2;

  int n_checks = 0;
  int n_fail   = 0;

  cache_ctrl_fsm_if bus ();
  cache_ctrl_fsm_if bus2 ();

  always #5 clk = ~clk;

  cache_ctrl_fsm #(.MEM_LAT(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rd_hits   (rd_hits),
    .rd_misses (rd_misses)
  );

  // Narrow-counter copy sharing the same stimulus, used to observe saturation.
  assign bus2.MemRead  = bus.MemRead;
  assign bus2.MemWrite = bus.MemWrite;
  assign bus2.hit      = bus.hit;

  cache_ctrl_fsm #(.MEM_LAT(4), .CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus2),
    .rd_hits   (rd_hits2),
    .rd_misses (rd_misses2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one CPU operation until stall is seen low, tallying strobe cycles.
  task automatic run_op(input logic fill_sets_hit,
                        output int n_stall, output int n_mr, output int n_mw,
                        output int n_fill, output int n_we, output logic done);
    logic fill_seen;
    n_stall = 0; n_mr = 0; n_mw = 0; n_fill = 0; n_we = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.stall)         n_stall++;
      if (bus.mem_read)      n_mr++;
      if (bus.mem_write)     n_mw++;
      if (bus.cache_fill)    n_fill++;
      if (bus.cache_word_we) n_we++;
      if (!bus.stall) done = 1'b1;
      fill_seen = bus.cache_fill;
      step();
      if (fill_seen && fill_sets_hit) bus.hit = 1'b1;
    end
  endtask

  task automatic check_op(input string tag, input int e_stall, input int e_mr,
                          input int e_mw, input int e_fill, input int e_we);
    int s, mr, mw, f, we;
    logic done;
    run_op(1'b1, s, mr, mw, f, we, done);
    check({tag, "_done"},  32'(done), 32'd1);
    check({tag, "_stall"}, s,  e_stall);
    check({tag, "_mrd"},   mr, e_mr);
    check({tag, "_mwr"},   mw, e_mw);
    check({tag, "_fill"},  f,  e_fill);
    check({tag, "_we"},    we, e_we);
  endtask

  initial begin
    rst          = 1'b0;
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b0;
    bus.hit      = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_stall", 32'(bus.stall),         0);
      check("rst_mrd",   32'(bus.mem_read),      0);
      check("rst_mwr",   32'(bus.mem_write),     0);
      check("rst_fill",  32'(bus.cache_fill),    0);
      check("rst_we",    32'(bus.cache_word_we), 0);
    end
    check("rst_hits", 32'(rd_hits),   0);
    check("rst_miss", 32'(rd_misses), 0);

    step();
    rst         = 1'b1;
    bus.MemRead = 1'b0;
    step();

    // Read miss: 6 stalled cycles, 4 memory cycles, one fill, then the hit retry.
    bus.MemRead = 1'b1;
    bus.hit     = 1'b0;
    check_op("rmiss", 6, 4, 0, 1, 0);
    check("rmiss_hits", 32'(rd_hits),   0);
    check("rmiss_miss", 32'(rd_misses), 1);

    // Four back-to-back hits: 16-bit counter reaches 4, 2-bit copy saturates at 3.
    bus.hit = 1'b1;
    for (int i = 0; i < 4; i++) check_op("rhit", 0, 0, 0, 0, 0);
    check("rhit_hits", 32'(rd_hits),  4);
    check("rhit_miss", 32'(rd_misses), 1);
    check("sat_hits",  32'(rd_hits2), 3);
    bus.MemRead = 1'b0;

    bus.MemWrite = 1'b1;
    bus.hit      = 1'b1;
    check_op("whit", 4, 0, 4, 0, 1);
    bus.hit = 1'b0;
    check_op("wmiss", 4, 0, 4, 0, 0);
    bus.MemWrite = 1'b0;
    @(negedge clk);
    check("widle_stall", 32'(bus.stall), 0);
    check("w_hits", 32'(rd_hits),   4);
    check("w_miss", 32'(rd_misses), 1);
    step();

    // Reset during the second RD_MEM cycle.
    bus.MemRead = 1'b1;
    bus.hit     = 1'b0;
    @(negedge clk);
    check("mr_first_stall", 32'(bus.stall), 1);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mr_rst_stall", 32'(bus.stall),    0);
    check("mr_rst_mrd",   32'(bus.mem_read), 0);
    step();
    rst         = 1'b1;
    bus.MemRead = 1'b0;
    @(negedge clk);
    check("mr_idle_fill",  32'(bus.cache_fill), 0);
    check("mr_idle_mrd",   32'(bus.mem_read),   0);
    check("mr_idle_stall", 32'(bus.stall),      0);
    check("mr_hits",       32'(rd_hits),        0);
    check("mr_miss",       32'(rd_misses),      0);
    step();
    bus.MemRead = 1'b1;
    check_op("rerun", 6, 4, 0, 1, 0);
    check("rerun_miss", 32'(rd_misses), 1);
    bus.MemRead = 1'b0;
    bus.hit     = 1'b0;
    step();

    // Simultaneous read and write is handled purely as a read.
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b1;
    check_op("both", 6, 4, 0, 1, 0);
    check("both_miss", 32'(rd_misses), 2);
    check("both_hits", 32'(rd_hits),   0);
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_fsm.md
Name: cache_ctrl_fsm

Overview:
Control FSM for the direct-mapped, write-through, no-write-allocate data cache. It sequences the cache arrays and the fixed-latency main memory for CPU loads and stores. It also generates the CPU stall and keeps read hit and read miss statistics. The tag/data arrays live in the cache datapath; this block only consumes the datapath's `hit` and drives its strobes.

Parameters:
MEM_LAT, 4, main-memory access latency in cycles per block read or word write (legal range 1..15)
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
MemRead  in  1  CPU load request; held until stall is sampled low
MemWrite  in  1  CPU store request; held until stall is sampled low
hit  in  1  datapath tag match AND valid for the current addr, combinational
stall  out  1  CPU must hold its request and address
mem_read  out  1  main-memory block read strobe
mem_write  out  1  main-memory word write strobe
cache_fill  out  1  datapath writes the returned block, tag and valid for the current index
cache_word_we  out  1  datapath writes data_in into the hit word
rd_hits  out  CNT_W  saturating count of read hits
rd_misses  out  CNT_W  saturating count of read misses

Behaviour:
- States: IDLE, RD_MEM, FILL, WR_MEM. A wait counter wcnt of width $clog2(MEM_LAT+1) and a flag refilled are registered.
- Reset (rst=0 at an edge): state=IDLE, wcnt=0, refilled=0, counters=0. While rst=0, all strobe outputs and stall are forced to 0.
- MemRead and MemWrite both high: treated as a read; MemWrite is ignored.
- IDLE, no request: all outputs are 0.
- IDLE, read and hit: stall=0, so the load completes this cycle. rd_hits increments unless refilled=1. refilled is cleared.
- IDLE, read and !hit: stall=1. rd_misses increments. Next state is RD_MEM with wcnt=0.
- RD_MEM: mem_read=1 and stall=1. wcnt increments each cycle. When wcnt==MEM_LAT-1, next state is FILL.
- FILL: cache_fill=1 and stall=1 for exactly one cycle. Next state is IDLE and refilled is set to 1.
- Read miss total: stall is high for MEM_LAT+2 cycles, then the IDLE hit cycle has stall=0.
- IDLE, write: stall=1 and cache_word_we=hit in this same cycle. Next state is WR_MEM with wcnt=0. A write never fills on a miss.
- WR_MEM: mem_write=1. stall=1 while wcnt<MEM_LAT-1. On the cycle where wcnt==MEM_LAT-1, stall=0 and next state is IDLE. The store therefore retires without re-triggering.
- Write total: stall is high for MEM_LAT cycles.
- A request dropped mid-operation (CPU violates the hold rule) does not abort the operation. The memory access and fill still complete.
- Reset asserted in any state: the FSM returns to IDLE at the next edge. No cache_fill is issued and counters clear.
- Counters saturate at all-ones.
- Outputs in IDLE are combinational from the inputs. In all other states they decode from state only.

Decomposition:
- Package cache_ctrl_pkg: state enum (IDLE, RD_MEM, FILL, WR_MEM) and the MEM_LAT default.
- One sub-module, sat_counter (CNT_W, inc, clr), instantiated twice for rd_hits and rd_misses.
- The wait counter stays inline in the FSM.

Test Plan:
- Reset: hold rst=0 for 4 cycles with MemRead=1 -> stall, mem_read, mem_write, cache_fill and cache_word_we are 0; rd_hits=rd_misses=0.
- Read miss, MEM_LAT=4: MemRead=1, hit=0, model sets hit=1 after cache_fill -> stall high for 6 cycles, mem_read high for 4, one cache_fill pulse, stall low on the 7th cycle; rd_misses=1, rd_hits=0.
- Read hit: MemRead=1, hit=1 -> stall=0 the same cycle, no memory strobes, rd_hits increments by 1 per accepted read.
- Write hit, then write miss, addr=3, data_in=7: cache_word_we pulses once for the hit and never for the miss. Each write has mem_write high for 4 cycles, stall high for 4 cycles, then IDLE.
- Reset at the 2nd RD_MEM cycle -> IDLE next edge, no cache_fill, counters 0; a new read after release restarts the miss sequence.
- Simultaneous MemRead=MemWrite=1, hit=0 -> read-miss sequence; mem_write and cache_word_we stay 0.
